run_ctrl: RTL and testbench

Run-control sequencer for the RISC-V core's program counter. Sits beside `top` and drives its `ena_pc`. After a start request and a short warm-up it enables the PC, and it stops fetch when an all-zero instruction word is executed or an external halt is requested. It also reports halt cause plus cycle and retired-instruction counts to the bench and debug logic.

---
 rtl/run_ctrl.sv | 144 ++++++++++++++
 tb/tb_run_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// Run-control sequencer driving the core's PC enable: warm-up, run, halt, and optional single-step.
// Optional feature macro: RUN_CTRL_STEP_EN enables the STEP state and step_req handling.
module run_ctrl #(
  parameter int unsigned START_DLY = 2,
  parameter int unsigned CW        = 32
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          start,
  input  logic          halt_req,
  input  logic          step_req,
  input  logic [31:0]   inst,
  output logic          ena_pc,
  output logic          busy,
  output logic          halted,
  output logic [1:0]    halt_cause,
  output logic [CW-1:0] cycle_cnt,
  output logic [CW-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WARMUP,
    RUN,
`ifdef RUN_CTRL_STEP_EN
    STEP,
`endif
    HALTED
  } state_t;

  localparam logic [3:0] WARM_LAST = 4'(START_DLY - 1);

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ZERO = 2'b01;
  localparam logic [1:0] CAUSE_EXT  = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  state_t     state;
  logic [3:0] warm_cnt;
  logic       inst_nz;

  assign inst_nz = |inst;

`ifndef RUN_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step_req;
`endif

  always_ff @(posedge clk) begin
    if (rst_) begin
      state      <= IDLE;
      ena_pc     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= CAUSE_NONE;
      cycle_cnt  <= '0;
      inst_cnt   <= '0;
      warm_cnt   <= '0;
    end else begin
      // ena_pc is high exactly in RUN/STEP, so it also gates the counters
      if (ena_pc) begin
        if (cycle_cnt != '1)
          cycle_cnt <= cycle_cnt + CW'(1);
        if (inst_nz && (inst_cnt != '1))
          inst_cnt <= inst_cnt + CW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= WARMUP;
            busy       <= 1'b1;
            warm_cnt   <= '0;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
            inst_cnt   <= '0;
          end
        end

        WARMUP: begin
          if (halt_req) begin
            state      <= HALTED;
            busy       <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= CAUSE_EXT;
          end else if (warm_cnt == WARM_LAST) begin
            state  <= RUN;
            ena_pc <= 1'b1;
          end else begin
            warm_cnt <= warm_cnt + 4'd1;
          end
        end

        RUN: begin
          if (!inst_nz || halt_req) begin
            state      <= HALTED;
            ena_pc     <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b1;
            halt_cause <= inst_nz ? CAUSE_EXT : CAUSE_ZERO;
          end
        end

`ifdef RUN_CTRL_STEP_EN
        STEP: begin
          state      <= HALTED;
          ena_pc     <= 1'b0;
          busy       <= 1'b0;
          halted     <= 1'b1;
          halt_cause <= inst_nz ? CAUSE_STEP : CAUSE_ZERO;
        end
`endif

        HALTED: begin
          if (start) begin
            state      <= WARMUP;
            busy       <= 1'b1;
            halted     <= 1'b0;
            warm_cnt   <= '0;
            halt_cause <= CAUSE_NONE;
            cycle_cnt  <= '0;
            inst_cnt   <= '0;
          end
`ifdef RUN_CTRL_STEP_EN
          else if (step_req) begin
            state  <= STEP;
            ena_pc <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
`endif
        end

        default: begin
          state  <= IDLE;
          ena_pc <= 1'b0;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: directed scenarios plus random stimulus against a mode-level model.
module tb_run_ctrl;

  localparam int unsigned START_DLY = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef RUN_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_, start, halt_req, step_req;
  logic [31:0] inst;

  logic        ena_pc, busy, halted;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_cnt, inst_cnt;

  logic        s_ena, s_busy, s_halted;
  logic [1:0]  s_cause;
  logic [3:0]  s_cyc, s_inst;

  run_ctrl #(.START_DLY(START_DLY), .CW(32)) u_dut (
    .clk(clk), .rst_(rst_), .start(start), .halt_req(halt_req), .step_req(step_req),
    .inst(inst), .ena_pc(ena_pc), .busy(busy), .halted(halted), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  run_ctrl #(.START_DLY(START_DLY), .CW(4)) u_sat (
    .clk(clk), .rst_(rst_), .start(start), .halt_req(halt_req), .step_req(step_req),
    .inst(inst), .ena_pc(s_ena), .busy(s_busy), .halted(s_halted), .halt_cause(s_cause),
    .cycle_cnt(s_cyc), .inst_cnt(s_inst)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: mode name, remaining warm-up cycles, unbounded counts
  string   mode = "idle";
  int      warm_left = 0;
  longint  cycles = 0;
  longint  insts = 0;
  int      cause = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic begin_run();
    mode = "warm";
    warm_left = START_DLY;
    cycles = 0;
    insts = 0;
    cause = 0;
  endtask

  task automatic model_edge();
    if (rst_) begin
      mode = "idle";
      warm_left = 0;
      cycles = 0;
      insts = 0;
      cause = 0;
    end else if (mode == "idle") begin
      if (start) begin_run();
    end else if (mode == "warm") begin
      if (halt_req) begin
        mode = "halt";
        cause = 2;
      end else begin
        warm_left--;
        if (warm_left == 0) mode = "run";
      end
    end else if (mode == "run") begin
      cycles++;
      if (inst != 0) insts++;
      if (inst == 0) begin
        mode = "halt";
        cause = 1;
      end else if (halt_req) begin
        mode = "halt";
        cause = 2;
      end
    end else if (mode == "step") begin
      cycles++;
      if (inst != 0) insts++;
      mode = "halt";
      cause = (inst == 0) ? 1 : 3;
    end else begin
      if (start) begin_run();
      else if (step_req && STEP_EN) mode = "step";
    end
  endtask

  task automatic check_all();
    logic e_ena, e_busy, e_halt;
    e_ena  = (mode == "run") || (mode == "step");
    e_busy = e_ena || (mode == "warm");
    e_halt = (mode == "halt");
    chk("ena_pc", ena_pc, e_ena);
    chk("busy", busy, e_busy);
    chk("halted", halted, e_halt);
    chk("halt_cause", halt_cause, cause);
    chk("cycle_cnt", cycle_cnt, sat(cycles, 32));
    chk("inst_cnt", inst_cnt, sat(insts, 32));
    chk("sat_ena_pc", s_ena, e_ena);
    chk("sat_busy", s_busy, e_busy);
    chk("sat_halted", s_halted, e_halt);
    chk("sat_halt_cause", s_cause, cause);
    chk("sat_cycle_cnt", s_cyc, sat(cycles, 4));
    chk("sat_inst_cnt", s_inst, sat(insts, 4));
  endtask

  // One clock: drive inputs at the falling edge, update model at the rising edge, check at the next falling edge
  task automatic tick(input logic r, input logic s, input logic h, input logic st, input logic [31:0] i);
    rst_ = r; start = s; halt_req = h; step_req = st; inst = i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_ = 1'b1; start = 1'b0; halt_req = 1'b0; step_req = 1'b0; inst = NOP;
    @(negedge clk);

    tick(1, 0, 0, 0, NOP);
    tick(1, 0, 0, 0, NOP);
    chk("reset_ena", ena_pc, 1'b0);
    chk("reset_halted", halted, 1'b0);
    chk("reset_cycle", cycle_cnt, 32'd0);

    tick(0, 1, 0, 0, NOP);
    chk("start_busy", busy, 1'b1);
    chk("start_ena_low", ena_pc, 1'b0);
    tick(0, 0, 0, 0, NOP);
    chk("warm_ena_low", ena_pc, 1'b0);
    tick(0, 0, 0, 0, NOP);
    chk("ena_rise", ena_pc, 1'b1);

    for (int k = 0; k < 5; k++) tick(0, 0, 0, 0, 32'h100 + 32'(k));
    tick(0, 0, 0, 0, 32'h0);
    chk("zero_ena", ena_pc, 1'b0);
    chk("zero_halted", halted, 1'b1);
    chk("zero_cause", halt_cause, 2'b01);
    chk("zero_inst_cnt", inst_cnt, 32'd5);
    chk("zero_cycle_cnt", cycle_cnt, 32'd6);

    tick(0, 1, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 1, 0, 32'h0);
    chk("both_cause", halt_cause, 2'b01);

    tick(0, 1, 0, 0, NOP);
    tick(0, 0, 1, 0, NOP);
    chk("warm_halt_cause", halt_cause, 2'b10);
    chk("warm_halt_cycle", cycle_cnt, 32'd0);

    tick(0, 0, 0, 1, NOP);
    chk("step_ena", ena_pc, STEP_EN);
    tick(0, 0, 1, 0, NOP);
    chk("step_ena_after", ena_pc, 1'b0);
    chk("step_halted", halted, 1'b1);
    chk("step_inst_cnt", inst_cnt, STEP_EN ? 32'd1 : 32'd0);
    chk("step_cause", halt_cause, STEP_EN ? 2'b11 : 2'b10);

    tick(0, 1, 0, 1, NOP);
    chk("start_beats_step", busy, 1'b1);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    for (int k = 0; k < 20; k++) tick(0, 0, 0, 0, 32'h33 + 32'(k));
    chk("sat_inst_15", s_inst, 4'd15);
    chk("sat_cycle_15", s_cyc, 4'd15);
    chk("wide_inst_20", inst_cnt, 32'd20);
    tick(0, 0, 1, 0, NOP);
    chk("sat_hold", s_cyc, 4'd15);
    chk("ext_cause", halt_cause, 2'b10);

    tick(0, 1, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(1, 0, 0, 0, NOP);
    chk("midrst_ena", ena_pc, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cycle", cycle_cnt, 32'd0);
    tick(0, 1, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    tick(0, 0, 0, 0, NOP);
    chk("restart_ena", ena_pc, 1'b1);

    for (int n = 0; n < 800; n++) begin
      logic r, s, h, st;
      logic [31:0] i;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 15) == 0);
      h  = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 7) == 0);
      i  = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom() | 32'h1);
      tick(r, s, h, st, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
